// File: rtl/lstm_activation_pipe.sv
// lstm_activation_pipe
//   Three-stage, multi-lane piecewise-quadratic tanh/sigmoid unit. Every lane
//   shares one valid/ready handshake, one mode bit and one tag per beat.
//   Ports:
//     clk, rst          rising-edge clock, asynchronous active-high reset
//     in_valid/in_ready input handshake; in_ready = !out_valid || out_ready
//     in_mode           0 = tanh, 1 = sigmoid, sampled with the beat
//     in_tag            sideband, returned unchanged on out_tag
//     in_data           LANES signed lanes, lane i at [i*DATA_BITS +: DATA_BITS]
//     out_valid/out_ready, out_tag, out_data  result beat, same lane layout

// One lane of the datapath. Pipeline control lives in the top level; the lane
// only sees a shared advance enable and the mode of the beat at S0 and S2.
module lstm_act_lane #(
  parameter int DATA_BITS = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv,
  input  logic                 mode_s0,
  input  logic                 mode_s2,
  input  logic [DATA_BITS-1:0] x_i,
  output logic [DATA_BITS-1:0] y_o
);
  localparam int D  = DATA_BITS;
  localparam int F  = FRAC_BITS;
  localparam int SH = F - 8;          // Q.8 table scaled up to the data format
  localparam int CW = F + 2;          // coefficient width, holds +1.0 signed
  localparam int PW = CW + D + 1;     // c1*a
  localparam int SW = CW + 2*D + 2;   // c2*a*a and the final sum

  localparam logic [D-1:0]         ONE_A   = D'(1 << F);
  localparam logic [D-1:0]         THREE_A = D'(3 << F);
  localparam logic [D-1:0]         SIX_A   = D'(6 << F);
  localparam logic signed [D-1:0]  MIN_X   = {1'b1, {(D-1){1'b0}}};
  localparam logic [D-1:0]         MAX_A   = {1'b0, {(D-1){1'b1}}};
  localparam logic signed [CW-1:0] C1_SEG0 = CW'(224 << SH);
  localparam logic signed [CW-1:0] C2_SEG0 = CW'(-46 << SH);
  localparam logic signed [CW-1:0] C0_SEG1 = CW'(253 << SH);
  localparam logic signed [CW-1:0] C1_SEG1 = CW'(1 << SH);
  localparam logic signed [CW-1:0] ONE_C   = CW'(1 << F);
  localparam logic signed [SW-1:0] ONE_S   = SW'(1 << F);

  // S1 state
  logic                 s1_neg_q, s1_neg_d;
  logic [D-1:0]         s1_a_q, s1_a_d;
  logic [1:0]           s1_seg_q, s1_seg_d;
  // S2 state
  logic                 s2_neg_q, s2_neg_d;
  logic [2*D-1:0]       s2_aa_q, s2_aa_d;
  logic signed [PW-1:0] s2_c1a_q, s2_c1a_d;
  logic signed [CW-1:0] s2_c0_q, s2_c0_d;
  logic signed [CW-1:0] s2_c2_q, s2_c2_d;
  // S3 state
  logic [D-1:0]         y_q, y_d;

  logic signed [D-1:0]  xs;
  logic [D-1:0]         a0;
  logic [1:0]           seg0;
  logic signed [CW-1:0] c0_sel, c1_sel, c2_sel;
  logic signed [SW-1:0] c2aa, sum;
  logic [D-1:0]         mag, t;

  always_comb begin
    // S1: optional sigmoid pre-shift, sign/magnitude split, segment pick.
    xs = mode_s0 ? ($signed(x_i) >>> 1) : $signed(x_i);
    if (!xs[D-1])        a0 = xs;
    else if (xs == MIN_X) a0 = MAX_A;    // |min| saturates, lands in segment 2
    else                 a0 = -xs;
    if (a0 >= SIX_A)        seg0 = 2'd2;
    else if (a0 >= THREE_A) seg0 = 2'd1;
    else                    seg0 = 2'd0;

    // S2: coefficient select. Segment 2 is expressed as c0 = 1.0, c1 = c2 = 0
    // so the S3 adder needs no special case.
    case (s1_seg_q)
      2'd0:    begin c0_sel = '0;      c1_sel = C1_SEG0; c2_sel = C2_SEG0; end
      2'd1:    begin c0_sel = C0_SEG1; c1_sel = C1_SEG1; c2_sel = '0;      end
      default: begin c0_sel = ONE_C;   c1_sel = '0;      c2_sel = '0;      end
    endcase

    // S3: quadratic sum, clamp to [0, 1.0], reapply sign, sigmoid post-op.
    c2aa = $signed({{(SW-CW){s2_c2_q[CW-1]}}, s2_c2_q})
         * $signed({{(SW-2*D){1'b0}}, s2_aa_q});
    sum  = $signed({{(SW-CW){s2_c0_q[CW-1]}}, s2_c0_q})
         + ($signed({{(SW-PW){s2_c1a_q[PW-1]}}, s2_c1a_q}) >>> F)
         + (c2aa >>> (2*F));
    if (sum[SW-1])        mag = '0;
    else if (sum > ONE_S) mag = ONE_A;
    else                  mag = sum[D-1:0];
    t = s2_neg_q ? -mag : mag;

    s1_neg_d = s1_neg_q; s1_a_d = s1_a_q; s1_seg_d = s1_seg_q;
    s2_neg_d = s2_neg_q; s2_aa_d = s2_aa_q; s2_c1a_d = s2_c1a_q;
    s2_c0_d  = s2_c0_q;  s2_c2_d = s2_c2_q; y_d = y_q;
    if (adv) begin
      s1_neg_d = xs[D-1];
      s1_a_d   = a0;
      s1_seg_d = seg0;
      s2_neg_d = s1_neg_q;
      s2_aa_d  = {{D{1'b0}}, s1_a_q} * {{D{1'b0}}, s1_a_q};
      s2_c1a_d = $signed({{(PW-CW){c1_sel[CW-1]}}, c1_sel})
               * $signed({{(PW-D){1'b0}}, s1_a_q});
      s2_c0_d  = c0_sel;
      s2_c2_d  = c2_sel;
      // t + 1.0 lies in [0, 2.0], so a plain right shift is the halving.
      y_d      = mode_s2 ? ((t + ONE_A) >> 1) : t;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_neg_q <= 1'b0; s1_a_q <= '0; s1_seg_q <= '0;
      s2_neg_q <= 1'b0; s2_aa_q <= '0; s2_c1a_q <= '0;
      s2_c0_q  <= '0;   s2_c2_q <= '0; y_q <= '0;
    end else begin
      s1_neg_q <= s1_neg_d; s1_a_q <= s1_a_d; s1_seg_q <= s1_seg_d;
      s2_neg_q <= s2_neg_d; s2_aa_q <= s2_aa_d; s2_c1a_q <= s2_c1a_d;
      s2_c0_q  <= s2_c0_d;  s2_c2_q <= s2_c2_d; y_q <= y_d;
    end
  end

  assign y_o = y_q;
endmodule

module lstm_activation_pipe #(
  parameter int DATA_BITS = 16,
  parameter int FRAC_BITS = 8,
  parameter int LANES     = 4,
  parameter int TAG_BITS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [TAG_BITS-1:0]        in_tag,
  input  logic [LANES*DATA_BITS-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TAG_BITS-1:0]        out_tag,
  output logic [LANES*DATA_BITS-1:0] out_data
);
  localparam int STAGES = 3;

  logic [STAGES:1]               vld_q, vld_d;
  logic [2:1]                    mode_q, mode_d;   // S3 post-op resolves at S2->S3
  logic [STAGES:1][TAG_BITS-1:0] tag_q, tag_d;
  logic                          advance;

  // The whole pipe moves as one; bubbles are kept, not squeezed out.
  always_comb begin
    advance = !vld_q[STAGES] || out_ready;
    vld_d   = vld_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    if (advance) begin
      vld_d  = {vld_q[STAGES-1:1], in_valid};
      mode_d = {mode_q[1], in_mode};
      tag_d  = {tag_q[STAGES-1:1], in_tag};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      mode_q <= '0;
      tag_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      tag_q  <= tag_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lstm_act_lane #(
      .DATA_BITS(DATA_BITS),
      .FRAC_BITS(FRAC_BITS)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .adv    (advance),
      .mode_s0(in_mode),
      .mode_s2(mode_q[2]),
      .x_i    (in_data[i*DATA_BITS +: DATA_BITS]),
      .y_o    (out_data[i*DATA_BITS +: DATA_BITS])
    );
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES];
  assign out_tag   = tag_q[STAGES];
endmodule
